// File: rtl/program_loader_pkg.sv
// Shared widths, types and FSM encoding for the program-store loader and datapath.
package program_loader_pkg;
  localparam int ADDR_W    = 11;
  localparam int DATA_W    = 16;
  localparam int MAX_WORDS = 2048;
  localparam int CNT_W     = 12;

  typedef logic [7:0]        byte_t;
  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  localparam cnt_t MAX_N = cnt_t'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA_LO, S_DATA_HI, S_WRITE, S_CHECK, S_DONE
  } state_e;
endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input, program-store write port and load status of the loader.
interface program_loader_if
  import program_loader_pkg::*;
();
  logic  start;
  logic  in_valid;
  byte_t in_data;
  logic  in_ready;
  logic  mem_we;
  addr_t mem_addr;
  word_t mem_wdata;
  logic  busy;
  logic  done;
  logic  err;
  cnt_t  words_written;

  // Loader side
  modport slave (
    input  start, in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, words_written
  );

  // Stream source / status consumer side
  modport master (
    output start, in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, words_written
  );
endinterface

// File: rtl/program_loader.sv
// Assembles a length-prefixed, checksummed byte stream into 16-bit words and
// writes them sequentially into the program store. All outputs come from
// registered state, so in_ready never depends combinationally on in_valid.
module program_loader
  import program_loader_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  program_loader_if.slave  bus
);
  state_e state_q, state_d;
  cnt_t   len_q,   len_d;
  addr_t  addr_q,  addr_d;
  byte_t  lo_q,    lo_d;
  byte_t  hi_q,    hi_d;
  byte_t  sum_q,   sum_d;
  logic   err_q,   err_d;
  cnt_t   ww_q,    ww_d;

  logic rdy;
  logic xfer;
  cnt_t n_len;

  assign rdy  = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) || (state_q == S_DATA_LO) ||
                (state_q == S_DATA_HI) || (state_q == S_CHECK);
  assign xfer = rdy && bus.in_valid;
  // Length as it will be once the high byte currently on the bus is taken
  assign n_len = {bus.in_data[3:0], len_q[7:0]};

  assign bus.in_ready      = rdy;
  assign bus.mem_we        = (state_q == S_WRITE);
  assign bus.mem_addr      = addr_q;
  assign bus.mem_wdata     = {hi_q, lo_q};
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.done          = (state_q == S_DONE);
  assign bus.err           = err_q;
  assign bus.words_written = ww_q;

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      addr_q  <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      sum_q   <= '0;
      err_q   <= 1'b0;
      ww_q    <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      sum_q   <= sum_d;
      err_q   <= err_d;
      ww_q    <= ww_d;
    end
  end

  // Next-state: stream parsing, word assembly, checksum and write sequencing
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    addr_d  = addr_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    sum_d   = sum_q;
    err_d   = err_q;
    ww_d    = ww_q;
    unique case (state_q)
      S_IDLE: if (bus.start) begin
        state_d = S_LEN_LO;
        err_d   = 1'b0;
        ww_d    = '0;
        sum_d   = '0;
        addr_d  = '0;
      end
      S_LEN_LO: if (xfer) begin
        len_d[7:0] = bus.in_data;
        state_d    = S_LEN_HI;
      end
      S_LEN_HI: if (xfer) begin
        len_d = n_len;
        if (bus.in_data[7:4] != 4'h0 || n_len == '0 || n_len > MAX_N) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_DATA_LO;
        end
      end
      S_DATA_LO: if (xfer) begin
        lo_d    = bus.in_data;
        sum_d   = sum_q + bus.in_data;
        state_d = S_DATA_HI;
      end
      S_DATA_HI: if (xfer) begin
        hi_d    = bus.in_data;
        sum_d   = sum_q + bus.in_data;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        ww_d = ww_q + cnt_t'(1);
        // Stop on the last word rather than incrementing, so 2048 never wraps to 0
        if ({1'b0, addr_q} == len_q - cnt_t'(1)) begin
          state_d = S_CHECK;
        end else begin
          addr_d  = addr_q + addr_t'(1);
          state_d = S_DATA_LO;
        end
      end
      S_CHECK: if (xfer) begin
        if (bus.in_data != sum_q) err_d = 1'b1;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_program_loader.sv
// Randomized scoreboard bench for program_loader: the driver pushes expected
// writes and done reports derived from the stream rules; a negedge monitor
// pops and compares whenever the DUT strobes mem_we or done.
module tb_program_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  program_loader_if bus ();
  program_loader dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  typedef struct { logic [10:0] addr; logic [15:0] data; } wr_t;
  typedef struct { logic err; logic [11:0] ww; } dn_t;

  wr_t         wr_q[$];
  dn_t         dn_q[$];
  logic [15:0] wq[$];
  int          checks = 0;
  int          errors = 0;
  logic        model_err = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare every write strobe and done pulse against the scoreboard
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      chk("ready_in_write", 64'(bus.in_ready), 64'd0);
      checks++;
      if (wr_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h", bus.mem_addr, bus.mem_wdata);
      end else begin
        wr_t e;
        e = wr_q.pop_front();
        if (bus.mem_addr !== e.addr || bus.mem_wdata !== e.data) begin
          errors++;
          $display("FAIL write: got addr 0x%0h data 0x%0h expected addr 0x%0h data 0x%0h",
                   bus.mem_addr, bus.mem_wdata, e.addr, e.data);
        end
      end
    end
    if (bus.done === 1'b1) begin
      checks++;
      if (dn_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: err %0b ww %0d", bus.err, bus.words_written);
      end else begin
        dn_t d;
        d = dn_q.pop_front();
        if (bus.err !== d.err || bus.words_written !== d.ww) begin
          errors++;
          $display("FAIL done: got err %0b ww %0d expected err %0b ww %0d",
                   bus.err, bus.words_written, d.err, d.ww);
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (bus.busy !== 1'b0 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) chk("idle_timeout", 64'(bus.busy), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_start();
    wait_idle();
    chk("err_sticky", 64'(bus.err), 64'(model_err));
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("after_start", {60'd0, bus.busy, bus.in_ready, bus.err, 1'b0}, {60'd0, 4'b1100});
    chk("ww_cleared", 64'(bus.words_written), 64'd0);
  endtask

  // One byte; optional idle gap first; start may be wiggled to show it is ignored
  task automatic send_byte(input logic [7:0] b, input bit gaps, input bit poke_start);
    int   n = 0;
    logic r;
    if (gaps) begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom);
      repeat ($urandom_range(1, 4)) @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    if (poke_start) bus.start = 1'($urandom);
    forever begin
      @(negedge clk);
      r = bus.in_ready;
      @(posedge clk);
      if (r === 1'b1) break;
      if (++n > 200) begin
        chk("xfer_timeout", 64'(r), 64'd1);
        break;
      end
    end
    #1;
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
  endtask

  // Full load from wq; reference behaviour taken straight from the stream rules
  task automatic run_load(input logic [15:0] len_field, input logic [7:0] cks_delta, input bit gaps);
    int         n;
    bit         legal;
    logic [7:0] sum = 8'd0;
    dn_t        d;
    n     = int'(len_field[11:0]);
    legal = (len_field[15:12] == 4'd0) && (n != 0) && (n <= 2048);
    do_start();
    send_byte(len_field[7:0], gaps, 1'b0);
    if (!legal) begin
      d.err = 1'b1; d.ww = 12'd0;
      dn_q.push_back(d);
      send_byte(len_field[15:8], gaps, 1'b0);
    end else begin
      send_byte(len_field[15:8], gaps, 1'b0);
      for (int i = 0; i < n; i++) begin
        wr_t w;
        w.addr = 11'(i);
        w.data = wq[i];
        wr_q.push_back(w);
        sum = sum + wq[i][7:0] + wq[i][15:8];
        send_byte(wq[i][7:0], gaps, 1'b1);
        send_byte(wq[i][15:8], gaps, 1'b1);
      end
      d.err = (cks_delta != 8'd0);
      d.ww  = 12'(n);
      dn_q.push_back(d);
      send_byte(sum + cks_delta, gaps, 1'b0);
    end
    model_err = d.err;
    wait_idle();
    chk("scoreboard_drained", 64'(wr_q.size() + dn_q.size()), 64'd0);
    chk("ww_final", 64'(bus.words_written), 64'(d.ww));
  endtask

  task automatic fill_random(input int n);
    wq.delete();
    for (int i = 0; i < n; i++) wq.push_back(16'($urandom));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs",
        {bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.busy, bus.done, bus.err, bus.words_written},
        '0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed three-word load, back-to-back then with gaps
    wq.delete();
    wq.push_back(16'h1234); wq.push_back(16'h0ABC); wq.push_back(16'hF00F);
    run_load(16'd3, 8'd0, 1'b0);
    run_load(16'd3, 8'd0, 1'b1);

    // Illegal lengths: zero, above the store size, nonzero top nibble
    run_load(16'h0000, 8'd0, 1'b0);
    run_load(16'h0801, 8'd0, 1'b0);
    run_load(16'h1003, 8'd0, 1'b1);

    // Checksum off by one: writes stand, err reported
    fill_random(2);
    run_load(16'd2, 8'd1, 1'b0);

    // Reset after the first word of four is written
    fill_random(4);
    do_start();
    send_byte(8'h04, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    begin
      wr_t w;
      w.addr = 11'd0; w.data = wq[0];
      wr_q.push_back(w);
    end
    send_byte(wq[0][7:0], 1'b0, 1'b0);
    send_byte(wq[0][15:8], 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_midload",
        {bus.in_ready, bus.mem_we, bus.busy, bus.done, bus.err, bus.words_written}, '0);
    model_err = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_no_more_writes", 64'(wr_q.size() + dn_q.size()), 64'd0);
    fill_random(1);
    run_load(16'd1, 8'd0, 1'b0);

    // Randomized loads
    for (int t = 0; t < 12; t++) begin
      int n = $urandom_range(1, 24);
      fill_random(n);
      run_load(16'(n), ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'd0,
               1'($urandom));
    end

    // Largest legal load
    fill_random(2048);
    run_load(16'h0800, 8'd0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    chk("no_wrap_write", 64'(wr_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
